jtag_tap_ctrl: RTL and testbench

Oversampled IEEE 1149.1 TAP controller running entirely in the `clk_i` domain. It sequences the 16-state TAP FSM from pre-synchronized TCK/TMS/TDI, and owns the instruction register and the IDCODE and BYPASS data registers. It also hands one user-defined DR (e.g. the debug module interface) to an external block through capture/shift/update strobes. It sits between the chip JTAG pads (after the synchronizers) and the debug/DFT logic, and returns the chip IDCODE identity value.

---
 rtl/jtag_tap_ctrl.sv | 177 +++++++++++++++++
 tb/tb_jtag_tap_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : jtag_tap_ctrl
// Purpose  : Oversampled IEEE 1149.1 TAP controller in the system clock domain,
//            owning IR, IDCODE and BYPASS and strobing one external user DR.
// Revision : 1.0 - initial release
// ============================================================================
module jtag_tap_ctrl #(
    parameter int unsigned          IR_LENGTH    = 5,
    parameter logic [31:0]          IDCODE_VALUE = 32'h04F5_484D,
    parameter logic [IR_LENGTH-1:0] USER_INSTR   = IR_LENGTH'('h10)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 tck_i,
    input  logic                 tms_i,
    input  logic                 tdi_i,
    output logic                 tdo_o,
    output logic                 tdo_oe_o,
    output logic [IR_LENGTH-1:0] ir_o,
    output logic [3:0]           tap_state_o,
    output logic                 user_sel_o,
    output logic                 dr_capture_o,
    output logic                 dr_shift_o,
    output logic                 dr_update_o,
    input  logic                 user_tdo_i
);

    typedef enum logic [3:0] {
        ST_TLR      = 4'hF,
        ST_RTI      = 4'hC,
        ST_SEL_DR   = 4'h7,
        ST_CAP_DR   = 4'h6,
        ST_SH_DR    = 4'h2,
        ST_EX1_DR   = 4'h1,
        ST_PAUSE_DR = 4'h3,
        ST_EX2_DR   = 4'h0,
        ST_UPD_DR   = 4'h5,
        ST_SEL_IR   = 4'h4,
        ST_CAP_IR   = 4'hE,
        ST_SH_IR    = 4'hA,
        ST_EX1_IR   = 4'h9,
        ST_PAUSE_IR = 4'hB,
        ST_EX2_IR   = 4'h8,
        ST_UPD_IR   = 4'hD
    } tap_state_e;

    localparam logic [IR_LENGTH-1:0] c_ir_idcode  = IR_LENGTH'(1);
    localparam logic [IR_LENGTH-1:0] c_ir_capture = IR_LENGTH'(2'b01);

    tap_state_e           r_state;
    tap_state_e           w_next_state;
    logic                 r_tck_q;
    logic                 w_rise;
    logic                 w_fall;
    logic [IR_LENGTH-1:0] r_ir;
    logic [IR_LENGTH-1:0] r_ir_shift;
    logic                 r_user_sel;
    logic [31:0]          r_idcode_sr;
    logic                 r_bypass;
    logic                 r_tdo;
    logic                 r_tdo_oe;
    logic                 w_sel_idcode;
    logic                 w_dr_lsb;

    assign w_rise       = tck_i & ~r_tck_q;
    assign w_fall       = ~tck_i & r_tck_q;
    assign w_sel_idcode = (r_ir == c_ir_idcode);
    assign w_dr_lsb     = r_user_sel   ? user_tdo_i :
                          w_sel_idcode ? r_idcode_sr[0] : r_bypass;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_TLR;
        end else if (w_rise) begin
            r_state <= w_next_state;
        end
    end

    // Strobes are gated by rst_i so a reset landing on an edge never leaks one.
    always_comb begin
        w_next_state = r_state;
        dr_capture_o = 1'b0;
        dr_shift_o   = 1'b0;
        dr_update_o  = 1'b0;
        case (r_state)
            ST_TLR:      w_next_state = tms_i ? ST_TLR    : ST_RTI;
            ST_RTI:      w_next_state = tms_i ? ST_SEL_DR : ST_RTI;
            ST_SEL_DR:   w_next_state = tms_i ? ST_SEL_IR : ST_CAP_DR;
            ST_CAP_DR:   w_next_state = tms_i ? ST_EX1_DR : ST_SH_DR;
            ST_SH_DR:    w_next_state = tms_i ? ST_EX1_DR : ST_SH_DR;
            ST_EX1_DR:   w_next_state = tms_i ? ST_UPD_DR : ST_PAUSE_DR;
            ST_PAUSE_DR: w_next_state = tms_i ? ST_EX2_DR : ST_PAUSE_DR;
            ST_EX2_DR:   w_next_state = tms_i ? ST_UPD_DR : ST_SH_DR;
            ST_UPD_DR:   w_next_state = tms_i ? ST_SEL_DR : ST_RTI;
            ST_SEL_IR:   w_next_state = tms_i ? ST_TLR    : ST_CAP_IR;
            ST_CAP_IR:   w_next_state = tms_i ? ST_EX1_IR : ST_SH_IR;
            ST_SH_IR:    w_next_state = tms_i ? ST_EX1_IR : ST_SH_IR;
            ST_EX1_IR:   w_next_state = tms_i ? ST_UPD_IR : ST_PAUSE_IR;
            ST_PAUSE_IR: w_next_state = tms_i ? ST_EX2_IR : ST_PAUSE_IR;
            ST_EX2_IR:   w_next_state = tms_i ? ST_UPD_IR : ST_SH_IR;
            ST_UPD_IR:   w_next_state = tms_i ? ST_SEL_DR : ST_RTI;
            default:     w_next_state = ST_TLR;
        endcase
        if (r_user_sel && !rst_i) begin
            dr_capture_o = w_rise && (r_state == ST_CAP_DR);
            dr_shift_o   = w_rise && (r_state == ST_SH_DR);
            dr_update_o  = w_fall && (r_state == ST_UPD_DR);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tck_q     <= 1'b0;
            r_ir        <= c_ir_idcode;
            r_user_sel  <= 1'b0;
            r_ir_shift  <= '0;
            r_idcode_sr <= '0;
            r_bypass    <= 1'b0;
            r_tdo       <= 1'b0;
            r_tdo_oe    <= 1'b0;
        end else begin
            r_tck_q <= tck_i;
            if (w_rise) begin
                case (r_state)
                    ST_CAP_IR: r_ir_shift <= c_ir_capture;
                    ST_SH_IR:  r_ir_shift <= {tdi_i, r_ir_shift[IR_LENGTH-1:1]};
                    ST_CAP_DR: begin
                        r_idcode_sr <= IDCODE_VALUE;
                        r_bypass    <= 1'b0;
                    end
                    ST_SH_DR: begin
                        if (!r_user_sel) begin
                            if (w_sel_idcode) begin
                                r_idcode_sr <= {tdi_i, r_idcode_sr[31:1]};
                            end else begin
                                r_bypass <= tdi_i;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            if (w_fall) begin
                r_tdo    <= 1'b0;
                r_tdo_oe <= 1'b0;
                case (r_state)
                    ST_SH_IR: begin
                        r_tdo    <= r_ir_shift[0];
                        r_tdo_oe <= 1'b1;
                    end
                    ST_SH_DR: begin
                        r_tdo    <= w_dr_lsb;
                        r_tdo_oe <= 1'b1;
                    end
                    ST_UPD_IR: begin
                        r_ir       <= r_ir_shift;
                        r_user_sel <= (r_ir_shift == USER_INSTR);
                    end
                    default: ;
                endcase
            end
            if (r_state == ST_TLR) begin
                r_ir       <= c_ir_idcode;
                r_user_sel <= (c_ir_idcode == USER_INSTR);
            end
        end
    end

    assign tdo_o       = r_tdo;
    assign tdo_oe_o    = r_tdo_oe;
    assign ir_o        = r_ir;
    assign user_sel_o  = r_user_sel;
    assign tap_state_o = r_state;

endmodule
`default_nettype wire

// File: tb/tb_jtag_tap_ctrl.sv
`default_nettype none
// Testbench for jtag_tap_ctrl: directed scans plus random TMS/TDI walks checked
// against a table-driven TAP reference model.
module tb_jtag_tap_ctrl;

    localparam logic [3:0] S_TLR = 4'hF, S_RTI = 4'hC;
    localparam logic [3:0] S_SDR = 4'h7, S_CDR = 4'h6, S_SHDR = 4'h2, S_E1DR = 4'h1;
    localparam logic [3:0] S_PDR = 4'h3, S_E2DR = 4'h0, S_UDR = 4'h5;
    localparam logic [3:0] S_SIR = 4'h4, S_CIR = 4'hE, S_SHIR = 4'hA, S_E1IR = 4'h9;
    localparam logic [3:0] S_PIR = 4'hB, S_E2IR = 4'h8, S_UIR = 4'hD;
    localparam logic [31:0] IDCODE = 32'h04F5_484D;
    localparam logic [4:0]  USER   = 5'h10;

    logic       clk = 1'b0;
    logic       rst_i, tck_i, tms_i, tdi_i, user_tdo_i;
    logic       tdo_o, tdo_oe_o, user_sel_o, dr_capture_o, dr_shift_o, dr_update_o;
    logic [4:0] ir_o;
    logic [3:0] tap_state_o;

    jtag_tap_ctrl #(
        .IR_LENGTH    (5),
        .IDCODE_VALUE (IDCODE),
        .USER_INSTR   (USER)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .tck_i        (tck_i),
        .tms_i        (tms_i),
        .tdi_i        (tdi_i),
        .tdo_o        (tdo_o),
        .tdo_oe_o     (tdo_oe_o),
        .ir_o         (ir_o),
        .tap_state_o  (tap_state_o),
        .user_sel_o   (user_sel_o),
        .dr_capture_o (dr_capture_o),
        .dr_shift_o   (dr_shift_o),
        .dr_update_o  (dr_update_o),
        .user_tdo_i   (user_tdo_i)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model
    logic [3:0]  nxt0 [0:15];
    logic [3:0]  nxt1 [0:15];
    logic [3:0]  m_state;
    logic [4:0]  m_ir, m_irsh;
    logic [31:0] m_id;
    logic        m_byp, m_tdo, m_oe, m_usel;
    int exp_cap = 0, exp_sh = 0, exp_upd = 0;
    int obs_cap = 0, obs_sh = 0, obs_upd = 0;
    bit tdo_q [$];

    always @(negedge clk) begin
        #1;
        if (dr_capture_o) obs_cap++;
        if (dr_shift_o)   obs_sh++;
        if (dr_update_o)  obs_upd++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_row(input logic [3:0] s, input logic [3:0] n0, input logic [3:0] n1);
        nxt0[s] = n0;
        nxt1[s] = n1;
    endtask

    task automatic model_reset();
        m_state = S_TLR; m_ir = 5'h01; m_irsh = '0; m_id = '0;
        m_byp = 1'b0; m_tdo = 1'b0; m_oe = 1'b0; m_usel = 1'b0;
    endtask

    task automatic model_rise(input logic tms, input logic tdi);
        if (m_state == S_CIR) m_irsh = 5'b00001;
        if (m_state == S_SHIR) m_irsh = {tdi, m_irsh[4:1]};
        if (m_state == S_CDR) begin
            m_id = IDCODE;
            m_byp = 1'b0;
            if (m_usel) exp_cap++;
        end
        if (m_state == S_SHDR) begin
            if (m_ir == USER) exp_sh++;
            else if (m_ir == 5'h01) m_id = {tdi, m_id[31:1]};
            else m_byp = tdi;
        end
        m_state = tms ? nxt1[m_state] : nxt0[m_state];
        if (m_state == S_TLR) begin
            m_ir = 5'h01;
            m_usel = 1'b0;
        end
    endtask

    task automatic model_fall(input logic utdo);
        m_tdo = 1'b0;
        m_oe  = 1'b0;
        if (m_state == S_UIR) begin
            m_ir = m_irsh;
            m_usel = (m_irsh == USER);
        end
        if (m_state == S_UDR && m_usel) exp_upd++;
        if (m_state == S_SHIR) begin
            m_tdo = m_irsh[0];
            m_oe = 1'b1;
        end
        if (m_state == S_SHDR) begin
            m_tdo = (m_ir == USER) ? utdo : (m_ir == 5'h01) ? m_id[0] : m_byp;
            m_oe = 1'b1;
        end
    endtask

    // One full TCK period (2 clk high, 2 clk low), then compare against the model.
    task automatic tck_cycle(input logic tms, input logic tdi, input logic utdo);
        tms_i = tms; tdi_i = tdi; user_tdo_i = utdo; tck_i = 1'b1;
        model_rise(tms, tdi);
        repeat (2) @(negedge clk);
        tck_i = 1'b0;
        model_fall(utdo);
        repeat (2) @(negedge clk);
        check("state", 32'(tap_state_o), 32'(m_state));
        check("tdo", 32'(tdo_o), 32'(m_tdo));
        check("tdo_oe", 32'(tdo_oe_o), 32'(m_oe));
        check("ir", 32'(ir_o), 32'(m_ir));
        check("user_sel", 32'(user_sel_o), 32'(m_usel));
        if (tdo_oe_o) tdo_q.push_back(tdo_o);
    endtask

    function automatic logic [63:0] q_word();
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < tdo_q.size() && i < 64; i++) w[i] = tdo_q[i];
        return w;
    endfunction

    task automatic ir_scan(input logic [4:0] val);
        tdo_q.delete();
        tck_cycle(1'b1, 1'b0, 1'b0);
        tck_cycle(1'b1, 1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tck_cycle(i == 4, val[i], 1'b0);
        tck_cycle(1'b1, 1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0, 1'b0);
    endtask

    // RTI -> DR scan of nbits -> RTI, optionally parking in PauseDR after pause_at shifts.
    task automatic dr_scan(input int nbits, input int pause_at, input logic [63:0] din,
                           input logic [63:0] utdo);
        logic last;
        int c0, s0, u0;
        tdo_q.delete();
        tck_cycle(1'b1, 1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0, utdo[0]);
        for (int i = 0; i < nbits; i++) begin
            last = (i == nbits - 1) || (i == pause_at - 1);
            tck_cycle(last, din[i], last ? 1'b0 : utdo[i+1]);
            if (i == pause_at - 1 && i != nbits - 1) begin
                tck_cycle(1'b0, 1'b0, 1'b0);
                c0 = obs_cap; s0 = obs_sh; u0 = obs_upd;
                repeat (3) tck_cycle(1'b0, 1'($urandom), 1'($urandom));
                tck_cycle(1'b1, 1'($urandom), 1'b0);
                check("pause_strobes", 32'(obs_cap - c0 + obs_sh - s0 + obs_upd - u0), 32'd0);
                tck_cycle(1'b0, 1'b0, utdo[i+1]);
            end
        end
        tck_cycle(1'b1, 1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int c0, s0, u0;
        set_row(S_TLR,  S_RTI,  S_TLR);  set_row(S_RTI,  S_RTI,  S_SDR);
        set_row(S_SDR,  S_CDR,  S_SIR);  set_row(S_CDR,  S_SHDR, S_E1DR);
        set_row(S_SHDR, S_SHDR, S_E1DR); set_row(S_E1DR, S_PDR,  S_UDR);
        set_row(S_PDR,  S_PDR,  S_E2DR); set_row(S_E2DR, S_SHDR, S_UDR);
        set_row(S_UDR,  S_RTI,  S_SDR);  set_row(S_SIR,  S_CIR,  S_TLR);
        set_row(S_CIR,  S_SHIR, S_E1IR); set_row(S_SHIR, S_SHIR, S_E1IR);
        set_row(S_E1IR, S_PIR,  S_UIR);  set_row(S_PIR,  S_PIR,  S_E2IR);
        set_row(S_E2IR, S_SHIR, S_UIR);  set_row(S_UIR,  S_RTI,  S_SDR);

        rst_i = 1'b1; tck_i = 1'b0; tms_i = 1'b1; tdi_i = 1'b0; user_tdo_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", 32'(tap_state_o), 32'hF);
        check("rst_ir", 32'(ir_o), 32'h01);
        check("rst_tdo", 32'(tdo_o), 32'd0);
        check("rst_tdo_oe", 32'(tdo_oe_o), 32'd0);
        check("rst_user_sel", 32'(user_sel_o), 32'd0);
        check("rst_strobes", 32'({dr_capture_o, dr_shift_o, dr_update_o}), 32'd0);
        rst_i = 1'b0;
        model_reset();
        @(negedge clk);

        tck_cycle(1'b0, 1'b0, 1'b0);
        dr_scan(32, 0, {$urandom, $urandom}, 64'd0);
        check("idcode_word", q_word()[31:0], IDCODE);
        check("idcode_len", 32'(tdo_q.size()), 32'd32);

        ir_scan(5'h1F);
        check("ir_capture_bits", q_word()[31:0], 32'h01);
        check("ir_capture_len", 32'(tdo_q.size()), 32'd5);
        check("ir_all_ones", 32'(ir_o), 32'h1F);

        dr_scan(8, 0, 64'hA5, 64'd0);
        check("bypass_word", q_word()[31:0], 32'h4A);
        check("bypass_len", 32'(tdo_q.size()), 32'd8);

        ir_scan(USER);
        check("user_sel", 32'(user_sel_o), 32'd1);
        c0 = obs_cap; s0 = obs_sh; u0 = obs_upd;
        dr_scan(4, 0, {$urandom, $urandom}, 64'b1101);
        check("user_tdo", q_word()[31:0], 32'hD);
        check("user_cap_cnt", 32'(obs_cap - c0), 32'd1);
        check("user_shift_cnt", 32'(obs_sh - s0), 32'd4);
        check("user_upd_cnt", 32'(obs_upd - u0), 32'd1);

        c0 = obs_cap; s0 = obs_sh; u0 = obs_upd;
        dr_scan(6, 3, {$urandom, $urandom}, {$urandom, $urandom});
        check("pause_user_shift_cnt", 32'(obs_sh - s0), 32'd6);
        check("pause_user_cap_cnt", 32'(obs_cap - c0), 32'd1);
        check("pause_user_upd_cnt", 32'(obs_upd - u0), 32'd1);

        ir_scan(5'h01);
        dr_scan(32, 10, {$urandom, $urandom}, 64'd0);
        check("pause_idcode_word", q_word()[31:0], IDCODE);
        check("pause_idcode_len", 32'(tdo_q.size()), 32'd32);

        ir_scan(5'h1F);
        tck_cycle(1'b1, 1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0, 1'b0);
        repeat (5) tck_cycle(1'b1, 1'($urandom), 1'b0);
        check("tlr_state", 32'(tap_state_o), 32'hF);
        check("tlr_ir", 32'(ir_o), 32'h01);
        check("tlr_tdo_oe", 32'(tdo_oe_o), 32'd0);
        tck_cycle(1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++)
            tck_cycle(1'($urandom_range(0, 9) < 3), 1'($urandom), 1'($urandom));
        check("rand_cap_cnt", 32'(obs_cap), 32'(exp_cap));
        check("rand_shift_cnt", 32'(obs_sh), 32'(exp_sh));
        check("rand_upd_cnt", 32'(obs_upd), 32'(exp_upd));

        repeat (5) tck_cycle(1'b1, 1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0, 1'b0);
        ir_scan(USER);
        tck_cycle(1'b1, 1'b0, 1'b0);
        tck_cycle(1'b1, 1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0, 1'b0);
        tck_cycle(1'b0, 1'b1, 1'b0);
        tck_cycle(1'b0, 1'b1, 1'b0);
        u0 = obs_upd;
        rst_i = 1'b1; tck_i = 1'b1; tms_i = 1'b1;
        @(negedge clk);
        check("midrst_state", 32'(tap_state_o), 32'hF);
        check("midrst_ir", 32'(ir_o), 32'h01);
        check("midrst_user_sel", 32'(user_sel_o), 32'd0);
        check("midrst_tdo_oe", 32'(tdo_oe_o), 32'd0);
        tck_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("midrst_no_update", 32'(obs_upd), 32'(u0));
        check("midrst_state_held", 32'(tap_state_o), 32'hF);
        check("final_cap_cnt", 32'(obs_cap), 32'(exp_cap));
        check("final_shift_cnt", 32'(obs_sh), 32'(exp_sh));
        check("final_upd_cnt", 32'(obs_upd), 32'(exp_upd));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
